// File: rtl/phase_sequencer.sv
// Instruction-phase sequencer feeding the register file.
// Walks each instruction through FETCH/EXECUTE/WRITEBACK, each split into
// phases X, Y and Z, and emits one strobe per phase. It also handles memory
// wait in phase Y, skipping writeback, halting at instruction boundaries,
// single-stepping and counting retired instructions.
module phase_sequencer #(
  parameter int RESET_RUN   = 1,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   c_CLOCK,
  input  logic                   c_RESET,
  input  logic                   i_WAIT,
  input  logic                   i_SKIPWB,
  input  logic                   i_HALT,
  input  logic                   i_STEP,
  output logic [1:0]             o_STATE,
  output logic                   o_CLOCKX,
  output logic                   o_CLOCKY,
  output logic                   o_CLOCKZ,
  output logic                   o_HALTED,
  output logic                   o_RETIRE,
  output logic [COUNT_WIDTH-1:0] o_ICOUNT
);

  typedef enum logic [1:0] {
    ST_HALT      = 2'd0,
    ST_FETCH     = 2'd1,
    ST_EXECUTE   = 2'd2,
    ST_WRITEBACK = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    PH_X = 2'd0,
    PH_Y = 2'd1,
    PH_Z = 2'd2
  } phase_t;

  localparam state_t RESET_STATE = (RESET_RUN != 0) ? ST_FETCH : ST_HALT;

  state_t                 state_q, state_d;
  phase_t                 phase_q, phase_d;
  logic                   step_q, step_d;
  logic [COUNT_WIDTH-1:0] icount_q, icount_d;

  logic run;
  logic clk_x, clk_y, clk_z;
  logic retire;

  // Phase strobes and retire pulse, decoded from the registered phase.
  // Reset silences everything so an abandoned instruction leaves no trace.
  always_comb begin
    run    = (state_q != ST_HALT) && !c_RESET;
    clk_x  = run && (phase_q == PH_X);
    clk_y  = run && (phase_q == PH_Y) && !i_WAIT;
    clk_z  = run && (phase_q == PH_Z);
    retire = clk_z && ((state_q == ST_WRITEBACK) ||
                       ((state_q == ST_EXECUTE) && i_SKIPWB));
  end

  // Next-state logic: phase stepping, state transitions at phase Z,
  // halt/step handling at the instruction boundary and in HALT.
  always_comb begin
    state_d  = state_q;
    phase_d  = phase_q;
    step_d   = step_q;
    icount_d = icount_q;

    if (state_q == ST_HALT) begin
      // Phase stays parked at X so a resumed instruction starts cleanly.
      phase_d = PH_X;
      if (i_STEP) begin
        state_d = ST_FETCH;
        step_d  = 1'b1;
      end else if (!i_HALT) begin
        state_d = ST_FETCH;
        step_d  = 1'b0;
      end
    end else begin
      case (phase_q)
        PH_X: phase_d = PH_Y;
        PH_Y: begin
          // Memory wait stretches phase Y; the Y strobe fires only on exit.
          if (!i_WAIT) begin
            phase_d = PH_Z;
          end
        end
        PH_Z: begin
          phase_d = PH_X;
          if (retire) begin
            icount_d = icount_q + 1'b1;
            // A single-stepped instruction re-halts even with i_HALT low.
            if (i_HALT || step_q) begin
              state_d = ST_HALT;
              step_d  = 1'b0;
            end else begin
              state_d = ST_FETCH;
            end
          end else begin
            case (state_q)
              ST_FETCH:   state_d = ST_EXECUTE;
              ST_EXECUTE: state_d = ST_WRITEBACK;
              default:    state_d = ST_FETCH;
            endcase
          end
        end
        default: phase_d = PH_X;
      endcase
    end
  end

  // State register with synchronous active-high reset.
  always_ff @(posedge c_CLOCK) begin
    if (c_RESET) begin
      state_q  <= RESET_STATE;
      phase_q  <= PH_X;
      step_q   <= 1'b0;
      icount_q <= '0;
    end else begin
      state_q  <= state_d;
      phase_q  <= phase_d;
      step_q   <= step_d;
      icount_q <= icount_d;
    end
  end

  assign o_STATE  = state_q;
  assign o_CLOCKX = clk_x;
  assign o_CLOCKY = clk_y;
  assign o_CLOCKZ = clk_z;
  assign o_HALTED = (state_q == ST_HALT);
  assign o_RETIRE = retire;
  assign o_ICOUNT = icount_q;

endmodule
